seq_gen_sched: RTL and testbench

Two-requester scheduler for the shared 4-bit sequence generator (`seqGen4bit`). It arbitrates round-robin between two clients, holds the generator in reset while idle and drives its mode input `A`. For each granted burst it releases the generator for a programmed number of steps and streams the resulting `wxyz` words back, tagged with the requester ID. It sits between client logic and the single generator instance.

---
 rtl/seq_gen_sched_pkg.sv | 14 +
 rtl/rr_arb2.sv | 38 +++
 rtl/seq_gen_sched.sv | 153 +++++++++++++++
 tb/tb_seq_gen_sched.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_sched_pkg.sv
// Shared types and constants for the two-requester sequence generator scheduler.
package seq_gen_sched_pkg;

  localparam int LEN_W_DEF = 4;
  localparam int N_REQ     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer remembers which requester was served last.
module rr_arb2
  import seq_gen_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] win
);

  logic last_q;
  logic last_d;

  always_comb begin
    win    = '0;
    last_d = last_q;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = last_q ? 2'b01 : 2'b10;
      default: win = '0;
    endcase
    if (advance && (req != '0)) begin
      last_d = win[1];
    end
  end

  // Reset to "1 served last" so requester 0 wins the first contest.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/seq_gen_sched.sv
// Round-robin scheduler for the shared 4-bit sequence generator: grants bursts,
// runs the generator for a programmed step count and streams its outputs back.
//   state | meaning
//   IDLE  | generator held in reset, waiting for a request
//   LOAD  | grant pulse, burst parameters already captured
//   RUN   | generator released, one sample per cycle
//   DONE  | end-of-burst pulse, generator back in reset
module seq_gen_sched
  import seq_gen_sched_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_mode,
  input  logic [LEN_W-1:0] req_len0,
  input  logic [LEN_W-1:0] req_len1,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             gen_rst_n,
  output logic             gen_a,
  input  logic [3:0]       gen_wxyz,
  output logic             out_valid,
  output logic [3:0]       out_data,
  output logic             out_id,
  output logic             done,
  output logic             done_id
);

  sched_state_t     state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             cur_id_q, cur_id_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             gen_rst_n_q, gen_rst_n_d;
  logic             gen_a_q, gen_a_d;
  logic             out_valid_q, out_valid_d;
  logic [3:0]       out_data_q, out_data_d;
  logic             out_id_q, out_id_d;
  logic             done_q, done_d;
  logic             done_id_q, done_id_d;

  logic [N_REQ-1:0] win;
  logic             advance;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (advance),
    .win     (win)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_id_d    = cur_id_q;
    gnt_d       = '0;
    gen_rst_n_d = 1'b0;
    gen_a_d     = gen_a_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    done_d      = 1'b0;
    done_id_d   = done_id_q;
    advance     = 1'b0;

    case (state_q)
      IDLE: begin
        gen_a_d = 1'b0;
        if (req != '0) begin
          state_d  = LOAD;
          advance  = 1'b1;
          gnt_d    = win;
          cur_id_d = win[1];
          gen_a_d  = req_mode[win[1]];
          cnt_d    = win[1] ? req_len1 : req_len0;
        end
      end
      LOAD: begin
        state_d     = RUN;
        gen_rst_n_d = 1'b1;
      end
      RUN: begin
        out_valid_d = 1'b1;
        out_data_d  = gen_wxyz;
        out_id_d    = cur_id_q;
        // Wrapping decrement: a loaded 0 runs the full 2^LEN_W steps.
        cnt_d       = cnt_q - LEN_W'(1);
        if (cnt_q == LEN_W'(1)) begin
          state_d   = DONE;
          done_d    = 1'b1;
          done_id_d = cur_id_q;
          gen_a_d   = 1'b0;
        end else begin
          gen_rst_n_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        gen_a_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        gen_a_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cur_id_q    <= 1'b0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      gen_rst_n_q <= 1'b0;
      gen_a_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_id_q    <= cur_id_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      gen_rst_n_q <= gen_rst_n_d;
      gen_a_q     <= gen_a_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign gen_rst_n = gen_rst_n_q;
  assign gen_a     = gen_a_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign done      = done_q;
  assign done_id   = done_id_q;

endmodule

// File: tb/tb_seq_gen_sched.sv
// Bench for seq_gen_sched: directed scenarios plus randomized traffic against a
// cycle-timeline reference model, with a stub up/down counter as the generator.
module tb_seq_gen_sched;
  import seq_gen_sched_pkg::*;

  localparam int SZ = 4096;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req, req_mode;
  logic [3:0] req_len0, req_len1;
  logic [1:0] gnt;
  logic       busy, gen_rst_n, gen_a;
  logic [3:0] gen_wxyz;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_id, done, done_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_gen_sched #(.LEN_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_mode  (req_mode),
    .req_len0  (req_len0),
    .req_len1  (req_len1),
    .gnt       (gnt),
    .busy      (busy),
    .gen_rst_n (gen_rst_n),
    .gen_a     (gen_a),
    .gen_wxyz  (gen_wxyz),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .done      (done),
    .done_id   (done_id)
  );

  // Generator stub: up-counter when A=0, down-counter when A=1, reset value 0.
  logic [3:0] gen_q;
  assign gen_wxyz = gen_q;
  always @(posedge clk) begin
    if (gen_rst_n !== 1'b1) gen_q <= 4'd0;
    else if (gen_a) gen_q <= gen_q - 4'd1;
    else gen_q <= gen_q + 4'd1;
  end

  // Reference model: on each accepted request it writes the whole burst's
  // expected timeline into per-cycle arrays indexed by absolute cycle number.
  int cyc = 0;
  int m_idle_at = 0;
  bit m_last = 1'b1;
  bit [1:0] e_gnt[SZ];
  bit       e_busy[SZ], e_grn[SZ], e_a[SZ], e_valid[SZ], e_done[SZ];
  bit [3:0] e_data[SZ];
  bit       e_id[SZ], e_done_id[SZ];

  always @(posedge clk) begin : model
    int c, len, id;
    bit md;
    c = cyc;
    if (rst) begin
      for (int j = c + 1; j < c + 24 && j < SZ; j++) begin
        e_gnt[j] = 0; e_busy[j] = 0; e_grn[j] = 0; e_a[j] = 0;
        e_valid[j] = 0; e_done[j] = 0; e_data[j] = 0; e_id[j] = 0; e_done_id[j] = 0;
      end
      m_idle_at = c + 1;
      m_last = 1'b1;
    end else if (c >= m_idle_at && req != 2'b00 && c + 24 < SZ) begin
      if (req == 2'b11) id = m_last ? 0 : 1;
      else id = req[1] ? 1 : 0;
      m_last = (id == 1);
      len = (id == 1) ? int'(req_len1) : int'(req_len0);
      if (len == 0) len = 16;
      md = req_mode[id];
      e_gnt[c + 1] = (id == 1) ? 2'b10 : 2'b01;
      for (int j = c + 1; j <= c + 2 + len; j++) e_busy[j] = 1;
      for (int j = c + 1; j <= c + 1 + len; j++) e_a[j] = md;
      for (int j = c + 2; j <= c + 1 + len; j++) e_grn[j] = 1;
      for (int k = 0; k < len; k++) begin
        e_valid[c + 3 + k] = 1;
        e_data[c + 3 + k]  = md ? 4'((16 - k) % 16) : 4'(k % 16);
        e_id[c + 3 + k]    = (id == 1);
      end
      e_done[c + 2 + len]    = 1;
      e_done_id[c + 2 + len] = (id == 1);
      m_idle_at = c + 3 + len;
    end
    cyc = cyc + 1;
  end

  task automatic test_reset();
    rst = 1'b1; req = 2'b00; req_mode = 2'b00; req_len0 = 4'd1; req_len1 = 4'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (gen_rst_n !== 1'b0) begin
        errors++; $display("FAIL reset_gen_rst_n: got %b exp 0", gen_rst_n);
      end
    end
    checks++;
    if ({gnt, busy, gen_a, out_valid, out_data, out_id, done, done_id} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%b busy=%b a=%b v=%b d=%h id=%b done=%b did=%b exp all 0",
               gnt, busy, gen_a, out_valid, out_data, out_id, done, done_id);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    req_mode = 2'b00; req_len0 = 4'd4; req = 2'b01;
    @(negedge clk);
    checks++;
    if (gnt !== 2'b01) begin errors++; $display("FAIL single_gnt: got %b exp 01", gnt); end
    req = 2'b00;
    @(negedge clk);
    checks++;
    if (gen_rst_n !== 1'b1 || gen_a !== 1'b0 || out_valid !== 1'b0 || gnt !== 2'b00) begin
      errors++;
      $display("FAIL single_run_start: got grn=%b a=%b v=%b gnt=%b exp 1 0 0 00", gen_rst_n, gen_a, out_valid, gnt);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 4'(k) || out_id !== 1'b0) begin
        errors++;
        $display("FAIL single_sample%0d: got v=%b d=%h id=%b exp 1 %h 0", k, out_valid, out_data, out_id, 4'(k));
      end
      checks++;
      if (done !== 1'(k == 3)) begin
        errors++; $display("FAIL single_done%0d: got %b exp %b", k, done, 1'(k == 3));
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL single_end: got busy=%b v=%b exp 0 0", busy, out_valid);
    end
  endtask

  task automatic test_alternate();
    logic [1:0] g[4];
    int gc[4];
    int ng = 0;
    logic [3:0] s0[$], s1[$];
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_len0 = 4'd2; req_len1 = 4'd2; req_mode = 2'b10; req = 2'b11;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (gnt !== 2'b00 && ng < 4) begin
        g[ng] = gnt; gc[ng] = n; ng++;
        if (ng == 3) req = 2'b00;
      end
      if (out_valid === 1'b1) begin
        if (out_id === 1'b1) s1.push_back(out_data);
        else s0.push_back(out_data);
      end
    end
    checks++;
    if (ng != 3) begin
      errors++; $display("FAIL alt_grant_count: got %0d exp 3", ng);
    end else begin
      checks++;
      if (g[0] !== 2'b01 || g[1] !== 2'b10 || g[2] !== 2'b01) begin
        errors++; $display("FAIL alt_grant_order: got %b %b %b exp 01 10 01", g[0], g[1], g[2]);
      end
      checks++;
      if (gc[1] - gc[0] != 5 || gc[2] - gc[1] != 5) begin
        errors++; $display("FAIL alt_spacing: got %0d %0d exp 5 5", gc[1] - gc[0], gc[2] - gc[1]);
      end
    end
    checks++;
    if (s1.size() != 2 || s1[0] !== 4'h0 || s1[1] !== 4'hF) begin
      errors++; $display("FAIL alt_req1_data: got %0d samples exp 2 (0,F)", s1.size());
    end
    checks++;
    if (s0.size() != 4 || s0[0] !== 4'h0 || s0[1] !== 4'h1 || s0[2] !== 4'h0 || s0[3] !== 4'h1) begin
      errors++; $display("FAIL alt_req0_data: got %0d samples exp 4 (0,1,0,1)", s0.size());
    end
  endtask

  task automatic test_full_len();
    logic [3:0] s[$];
    int ndone = 0;
    int at_done = -1;
    logic did = 1'b0;
    req_mode = 2'b10; req_len1 = 4'd0; req = 2'b10;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (gnt !== 2'b00) req = 2'b00;
      if (out_valid === 1'b1) s.push_back(out_data);
      if (done === 1'b1) begin
        ndone++; did = done_id; at_done = s.size();
      end
    end
    checks++;
    if (s.size() != 16) begin
      errors++; $display("FAIL full_count: got %0d exp 16", s.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        checks++;
        if (s[k] !== 4'((16 - k) % 16)) begin
          errors++; $display("FAIL full_sample%0d: got %h exp %h", k, s[k], 4'((16 - k) % 16));
        end
      end
    end
    checks++;
    if (ndone != 1 || did !== 1'b1 || at_done != 16) begin
      errors++; $display("FAIL full_done: got n=%0d id=%b at=%0d exp 1 1 16", ndone, did, at_done);
    end
  endtask

  task automatic test_reset_abort();
    bit stray = 0;
    req_mode = 2'b00; req_len0 = 4'd4; req = 2'b01;
    @(negedge clk);
    req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || gen_rst_n !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: got busy=%b v=%b done=%b grn=%b exp 0 0 0 0", busy, out_valid, done, gen_rst_n);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || out_valid !== 1'b0) stray = 1;
    end
    checks++;
    if (stray) begin errors++; $display("FAIL abort_no_done: got activity exp none"); end
    req_len0 = 4'd2; req_len1 = 4'd2; req = 2'b11;
    @(negedge clk);
    checks++;
    if (gnt !== 2'b01) begin errors++; $display("FAIL abort_priority: got %b exp 01", gnt); end
    req = 2'b00;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_len_change();
    int nv = 0;
    int nd = 0;
    req_mode = 2'b00; req_len0 = 4'd4; req = 2'b01;
    @(negedge clk);
    req = 2'b00;
    @(negedge clk);
    req_len0 = 4'd7;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) nv++;
      if (done === 1'b1) nd++;
    end
    checks++;
    if (nv != 4 || nd != 1) begin
      errors++; $display("FAIL len_change: got %0d samples %0d done exp 4 1", nv, nd);
    end
  endtask

  task automatic test_random();
    int c;
    for (int i = 0; i < 800; i++) begin
      c = cyc;
      checks++;
      if (gnt !== e_gnt[c]) begin
        errors++; $display("FAIL rand_gnt@%0d: got %b exp %b", c, gnt, e_gnt[c]);
      end
      checks++;
      if ({busy, gen_rst_n, gen_a, out_valid, done} !== {e_busy[c], e_grn[c], e_a[c], e_valid[c], e_done[c]}) begin
        errors++;
        $display("FAIL rand_ctrl@%0d: got busy/grn/a/v/done=%b exp %b", c,
                 {busy, gen_rst_n, gen_a, out_valid, done}, {e_busy[c], e_grn[c], e_a[c], e_valid[c], e_done[c]});
      end
      if (e_valid[c]) begin
        checks++;
        if (out_data !== e_data[c] || out_id !== e_id[c]) begin
          errors++;
          $display("FAIL rand_data@%0d: got %h/%b exp %h/%b", c, out_data, out_id, e_data[c], e_id[c]);
        end
      end
      if (e_done[c]) begin
        checks++;
        if (done_id !== e_done_id[c]) begin
          errors++; $display("FAIL rand_done_id@%0d: got %b exp %b", c, done_id, e_done_id[c]);
        end
      end
      req      = 2'($urandom_range(0, 3));
      req_mode = 2'($urandom_range(0, 3));
      req_len0 = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 5));
      req_len1 = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 5));
      rst      = ($urandom_range(0, 79) == 0);
      @(negedge clk);
    end
    rst = 1'b0; req = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_full_len();
    test_reset_abort();
    test_len_change();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
